ctrl_decode_stage: RTL
======================

// Module: ctrl_decode_stage
// PURPOSE
//  Registered, parametrised successor to the combinational control decoder. Decodes
//  the opcode, immediate flag and immediate into the control bundle, holds it in one
//  pipeline register with valid/ready handshakes, and stalls issue for multi-cycle
//  ALU ops. Flags illegal opcodes. Sits between fetch and execute.
// PARAMETERS
//  OPW      5   opcode width; legal opcodes 0..20, all others illegal
//  DW       32  immediate width; DW-1 is the sign bit
//  ALUW     5   alusignal width
//  MUL_LAT  3   execute cycles for opcode 2 (MUL), >=1
//  DIV_LAT  8   execute cycles for opcodes 3 (DIV) and 4 (MOD), >=1
// PORTS
//  clk           in   1     clock, rising edge
//  rst           in   1     synchronous, active-high reset
//  flush         in   1     drop held instruction, abort any stall
//  in_valid      in   1     upstream instruction valid
//  in_ready      out  1     stage can accept
//  in_opcode     in   OPW   opcode
//  in_i          in   1     immediate-operand flag
//  in_imm        in   DW    immediate
//  out_valid     out  1     control bundle valid
//  out_ready     in   1     execute accepts
//  out_alusignal out  ALUW  ALU operation
//  out_isimm, out_iswb, out_isst, out_isld, out_isbeq, out_isbgt,
//  out_isubranch, out_iscall, out_isret  out 1 each  control flags
//  out_illegal   out  1     opcode outside 0..20; every other flag 0, alusignal 0
// BEHAVIOUR
//  Reset: all out_* = 0, in_ready = 1, FSM = EMPTY, counter = 0.
//  Decode table:
//   0..13  alusignal = opcode; iswb = 1, except 5 (CMP): iswb = 0.
//   1      if in_i && in_imm[DW-1]: alusignal = 0 (legacy SUB-negative-imm rule).
//   14 LD  alu 0, isld = 1, iswb = 1.       15 ST   alu 0, isst = 1.
//   16 BEQ alu 13, isbeq = 1.               17 BGT  alu 13, isbgt = 1.
//   18 B   alu 13, isubranch = 1.
//   19 CALL alu 13, isubranch = 1, iscall = 1, iswb = 1.
//   20 RET  alu 13, isubranch = 1, isret = 1.
//   isimm = in_i for every opcode. Illegal opcodes: only out_illegal = 1.
//  Latency: one cycle from in handshake (in_valid & in_ready) to out_valid.
//  FSM:
//   EMPTY: in_ready = 1. On accept, register the bundle and go to FULL.
//   FULL:  out_valid = 1; bundle is stable until the out handshake.
//          in_ready = out_ready & ~mc (mc = held op is 2/3/4). This gives back-to-back
//          throughput for single-cycle ops.
//          Out handshake, single-cycle op: accept the next instruction in the same
//          cycle (stay FULL), or go to EMPTY.
//          Out handshake, multi-cycle op: load cnt = LAT-1. Go to MC_WAIT if cnt > 0,
//          else to EMPTY.
//   MC_WAIT: in_ready = 0, out_valid = 0, cnt decrements each cycle. When cnt == 0,
//          go to EMPTY.
//  Counter width $clog2(max(MUL_LAT, DIV_LAT)) + 1. No wrap: it saturates at 0.
//  flush (highest priority below rst): next state EMPTY, out_valid = 0, cnt = 0.
//   An in_valid in the flush cycle is discarded.
//  Reset mid-stall: same as flush, and all outputs are cleared.
//  Illegal opcodes pass through as single-cycle ops. Raising a trap is execute's job.
//  out_* hold their last value while out_valid = 0; consumers qualify with out_valid.
// STRUCTURE
//  Shared package ctrl_pkg:
//   - opcode localparams (OP_ADD..OP_RET)
//   - ALU code constants (ALU_ADD = 0, ALU_CMP = 13)
//   - ctrl_bundle_t struct: the flags plus alusignal and illegal
//   - state enum EMPTY/FULL/MC_WAIT
//  Sub-module ctrl_decode_comb: pure combinational table, (opcode, i, imm) -> bundle.
//  Top level: pipeline register, FSM and stall counter.
// TESTING
//  1 Reset, then in opcode 0, i=0 -> next cycle out_valid=1, alu=0, iswb=1, other flags 0.
//  2 opcode 1, i=1, imm=32'hFFFF_FFF0 -> alu=0; same with imm=32'h10 -> alu=1.
//  3 MUL (2), out_ready=1, MUL_LAT=3 -> in_ready=0 for 2 cycles after the out
//    handshake, then 1. DIV_LAT=8 -> 7 cycles.
//  4 Stream of 0,14,15,19,20 with out_ready=1 -> one per cycle. Flags: LD isld&iswb,
//    CALL isubranch&iscall&iswb, RET isubranch&isret.
//  5 opcode 21 and 31 -> out_illegal=1, all other flags 0, single-cycle throughput.
//  6 flush during MC_WAIT (DIV, cnt=5) -> next cycle in_ready=1, out_valid=0.
//    rst asserted in FULL -> all outputs 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, ALU codes, control bundle and stage state for the decode stage
package ctrl_pkg;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_MUL  = 2;
  localparam int OP_DIV  = 3;
  localparam int OP_MOD  = 4;
  localparam int OP_CMP  = 5;
  localparam int OP_LAST_ALU = 13;
  localparam int OP_LD   = 14;
  localparam int OP_ST   = 15;
  localparam int OP_BEQ  = 16;
  localparam int OP_BGT  = 17;
  localparam int OP_B    = 18;
  localparam int OP_CALL = 19;
  localparam int OP_RET  = 20;

  // Every ALU code fits in 4 bits; the top level widens to its ALUW port.
  localparam int ALU_CODE_W = 4;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_CODE_W-1:0] ALU_CMP = 4'd13;

  typedef struct packed {
    logic [ALU_CODE_W-1:0] alusignal;
    logic                  isimm;
    logic                  iswb;
    logic                  isst;
    logic                  isld;
    logic                  isbeq;
    logic                  isbgt;
    logic                  isubranch;
    logic                  iscall;
    logic                  isret;
    logic                  illegal;
  } ctrl_bundle_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    MC_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// rtl/ctrl_decode_comb.sv - combinational decode table: opcode, immediate flag, immediate to control bundle
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter int OPW = 5,
  parameter int DW  = 32
) (
  input  logic [OPW-1:0] opcode,
  input  logic           i,
  input  logic [DW-1:0]  imm,
  output ctrl_bundle_t   bundle
);

  int unsigned op;

  // Only the sign bit of the immediate affects decode.
  logic unused_imm;
  assign unused_imm = ^imm[DW-2:0];

  always_comb begin
    bundle = '0;
    op     = 32'(opcode);
    if (op <= OP_LAST_ALU) begin
      bundle.alusignal = op[ALU_CODE_W-1:0];
      bundle.isimm     = i;
      bundle.iswb      = (op != OP_CMP);
      // Legacy rule: SUB with a negative immediate issues as ADD.
      if (op == OP_SUB && i && imm[DW-1]) bundle.alusignal = ALU_ADD;
    end else begin
      case (op)
        OP_LD: begin
          bundle.alusignal = ALU_ADD;
          bundle.isimm     = i;
          bundle.isld      = 1'b1;
          bundle.iswb      = 1'b1;
        end
        OP_ST: begin
          bundle.alusignal = ALU_ADD;
          bundle.isimm     = i;
          bundle.isst      = 1'b1;
        end
        OP_BEQ: begin
          bundle.alusignal = ALU_CMP;
          bundle.isimm     = i;
          bundle.isbeq     = 1'b1;
        end
        OP_BGT: begin
          bundle.alusignal = ALU_CMP;
          bundle.isimm     = i;
          bundle.isbgt     = 1'b1;
        end
        OP_B: begin
          bundle.alusignal = ALU_CMP;
          bundle.isimm     = i;
          bundle.isubranch = 1'b1;
        end
        OP_CALL: begin
          bundle.alusignal = ALU_CMP;
          bundle.isimm     = i;
          bundle.isubranch = 1'b1;
          bundle.iscall    = 1'b1;
          bundle.iswb      = 1'b1;
        end
        OP_RET: begin
          bundle.alusignal = ALU_CMP;
          bundle.isimm     = i;
          bundle.isubranch = 1'b1;
          bundle.isret     = 1'b1;
        end
        default: bundle.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// rtl/ctrl_decode_stage.sv - registered decode stage with valid/ready handshake and multi-cycle ALU stall
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int OPW     = 5,
  parameter int DW      = 32,
  parameter int ALUW    = 5,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_opcode,
  input  logic            in_i,
  input  logic [DW-1:0]   in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ALUW-1:0] out_alusignal,
  output logic            out_isimm,
  output logic            out_iswb,
  output logic            out_isst,
  output logic            out_isld,
  output logic            out_isbeq,
  output logic            out_isbgt,
  output logic            out_isubranch,
  output logic            out_iscall,
  output logic            out_isret,
  output logic            out_illegal
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

  state_t       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] lat_q, lat_in;
  logic          mc_q, mc_in;
  ctrl_bundle_t  bundle_q, dec;
  logic          accept;

  ctrl_decode_comb #(.OPW(OPW), .DW(DW)) u_decode (
    .opcode (in_opcode),
    .i      (in_i),
    .imm    (in_imm),
    .bundle (dec)
  );

  // Stall length is fixed at accept so the held op needs no re-decode later.
  always_comb begin
    mc_in  = 1'b0;
    lat_in = '0;
    if (in_opcode == OPW'(OP_MUL)) begin
      mc_in  = 1'b1;
      lat_in = MUL_LOAD;
    end else if (in_opcode == OPW'(OP_DIV) || in_opcode == OPW'(OP_MOD)) begin
      mc_in  = 1'b1;
      lat_in = DIV_LOAD;
    end
  end

  assign out_valid = (state_q == FULL);
  assign in_ready  = (state_q == EMPTY) || ((state_q == FULL) && out_ready && !mc_q);
  assign accept    = in_valid && in_ready && !flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      EMPTY: begin
        if (accept) state_d = FULL;
      end
      FULL: begin
        if (out_ready) begin
          if (mc_q) begin
            cnt_d   = lat_q;
            state_d = (lat_q != '0) ? MC_WAIT : EMPTY;
          end else begin
            state_d = accept ? FULL : EMPTY;
          end
        end
      end
      MC_WAIT: begin
        cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        // Leave as the count reaches zero so the stall lasts exactly LAT-1 cycles.
        if (cnt_q <= CW'(1)) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      cnt_q    <= '0;
      lat_q    <= '0;
      mc_q     <= 1'b0;
      bundle_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        bundle_q <= dec;
        mc_q     <= mc_in;
        lat_q    <= lat_in;
      end
    end
  end

  assign out_alusignal = ALUW'(bundle_q.alusignal);
  assign out_isimm     = bundle_q.isimm;
  assign out_iswb      = bundle_q.iswb;
  assign out_isst      = bundle_q.isst;
  assign out_isld      = bundle_q.isld;
  assign out_isbeq     = bundle_q.isbeq;
  assign out_isbgt     = bundle_q.isbgt;
  assign out_isubranch = bundle_q.isubranch;
  assign out_iscall    = bundle_q.iscall;
  assign out_isret     = bundle_q.isret;
  assign out_illegal   = bundle_q.illegal;

endmodule
